// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter/sequencer for the shared memory data port
//
// Purpose: arbitrates the CPU load/store unit (r0) and the program loader/debug
// port (r1) onto the single memory port. Round-robin with a bounded burst lock.
// Each command is latched, issued for one cycle (ACCESS), and completed one cycle
// later (RESP) with registered read data. Writes into the instruction bank can
// be suppressed.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rN_req_i/we_i/lock_i     command request, direction, keep-ownership hint
//   rN_addr_i/wdata_i        byte address (bit 0 ignored), write data
//   rN_gnt_o                 command is on the memory port this cycle
//   rN_done_o/err_o          completion pulse, suppressed-write flag
//   rN_rdata_o               last read data for that requester
//   mem_addr_o/we_o/wdata_o  memory address_bus / write_mode / incoming_data_bus
//   mem_rdata_i              memory data_bus (combinational read)
module mem_port_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 4,
  parameter bit IMEM_WP  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req_i,
  input  logic          r0_we_i,
  input  logic          r0_lock_i,
  input  logic [AW-1:0] r0_addr_i,
  input  logic [DW-1:0] r0_wdata_i,
  output logic          r0_gnt_o,
  output logic          r0_done_o,
  output logic          r0_err_o,
  output logic [DW-1:0] r0_rdata_o,
  input  logic          r1_req_i,
  input  logic          r1_we_i,
  input  logic          r1_lock_i,
  input  logic [AW-1:0] r1_addr_i,
  input  logic [DW-1:0] r1_wdata_i,
  output logic          r1_gnt_o,
  output logic          r1_done_o,
  output logic          r1_err_o,
  output logic [DW-1:0] r1_rdata_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e          state_q, state_d;
  logic            owner_q, last_q, lock_q, we_q, sup_q;
  logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q, rdata0_q, rdata1_q;

  logic            arb_phase, grant, winner, keep_owner;
  logic            sel_we, sel_lock;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // Arbitration and winner selection.
  always_comb begin
    arb_phase  = (state_q != ACCESS);
    grant      = arb_phase && (r0_req_i || r1_req_i);
    // The previous owner keeps a tie only while its lock is live and the burst is unsaturated.
    keep_owner = lock_q && (burst_cnt_q < CW'(LOCK_MAX));
    if (r0_req_i && r1_req_i) winner = keep_owner ? last_q : ~last_q;
    else                      winner = r1_req_i;
    sel_we    = winner ? r1_we_i    : r0_we_i;
    sel_lock  = winner ? r1_lock_i  : r0_lock_i;
    sel_addr  = winner ? r1_addr_i  : r0_addr_i;
    sel_wdata = winner ? r1_wdata_i : r0_wdata_i;
    // Re-grant under lock counts up (saturating); anything else starts a new burst.
    if ((winner == last_q) && lock_q)
      burst_cnt_d = (burst_cnt_q == CW'(LOCK_MAX)) ? burst_cnt_q : burst_cnt_q + CW'(1);
    else
      burst_cnt_d = CW'(1);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, RESP: state_d = grant ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // Command latch, arbitration history and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      we_q        <= 1'b0;
      sup_q       <= 1'b0;
      burst_cnt_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      if (grant) begin
        owner_q     <= winner;
        last_q      <= winner;
        lock_q      <= sel_lock;
        we_q        <= sel_we;
        sup_q       <= IMEM_WP && sel_we && (sel_addr[AW-1:AW-2] == 2'b00);
        burst_cnt_q <= burst_cnt_d;
        // Halfword aligned; the register also holds the port value outside ACCESS.
        mem_addr_q  <= sel_addr & ~AW'(1);
        mem_wdata_q <= sel_wdata;
      end
      if ((state_q == ACCESS) && !we_q) begin
        if (owner_q) rdata1_q <= mem_rdata_i;
        else         rdata0_q <= mem_rdata_i;
      end
    end
  end

  // Outputs; mem_we is combinational so an async reset removes it before the edge.
  always_comb begin
    r0_gnt_o    = (state_q == ACCESS) && !owner_q;
    r1_gnt_o    = (state_q == ACCESS) &&  owner_q;
    r0_done_o   = (state_q == RESP)   && !owner_q;
    r1_done_o   = (state_q == RESP)   &&  owner_q;
    r0_err_o    = r0_done_o && sup_q;
    r1_err_o    = r1_done_o && sup_q;
    mem_we_o    = (state_q == ACCESS) && we_q && !sup_q;
    mem_addr_o  = mem_addr_q;
    mem_wdata_o = mem_wdata_q;
    r0_rdata_o  = rdata0_q;
    r1_rdata_o  = rdata1_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [11:0] r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [15:0] r0_rdata, r1_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [0:2047];

  int vectors;
  int miscompares;

  mem_port_arbiter #(.AW(12), .DW(16), .LOCK_MAX(4), .IMEM_WP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .r0_req_i(r0_req), .r0_we_i(r0_we), .r0_lock_i(r0_lock), .r0_addr_i(r0_addr),
    .r0_wdata_i(r0_wdata), .r0_gnt_o(r0_gnt), .r0_done_o(r0_done), .r0_err_o(r0_err),
    .r0_rdata_o(r0_rdata),
    .r1_req_i(r1_req), .r1_we_i(r1_we), .r1_lock_i(r1_lock), .r1_addr_i(r1_addr),
    .r1_wdata_i(r1_wdata), .r1_gnt_o(r1_gnt), .r1_done_o(r1_done), .r1_err_o(r1_err),
    .r1_rdata_o(r1_rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: write on rising edge, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr[11:1]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[11:1]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {r1_gnt, r1_done, r1_err, r0_gnt, r0_done, r0_err, mem_we, 25'd0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int lock_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[12'h412 >> 1] = 16'h0018;
    mem[12'hFFC >> 1] = 16'hABCD;
    mem[12'hFFE >> 1] = 16'h1357;
    mem[12'h000 >> 1] = 16'hF0C8;
    mem[12'h404 >> 1] = 16'h7777;
    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
    step(); step();

    // Reset values
    chk("reset_ctrl", outs_vec(), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("reset_rdata", {r1_rdata, r0_rdata}, 32'h0);
    rst = 1'b0;

    // r0 reads 0x412
    r0_req = 1; r0_we = 0; r0_addr = 12'h412;
    step();
    chk("rd0_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd1);
    chk("rd0_addr", 32'(mem_addr), 32'h412);
    chk("rd0_we", 32'(mem_we), 32'd0);
    r0_req = 0;
    step();
    chk("rd0_done", {30'd0, r1_done, r0_done}, 32'd1);
    chk("rd0_err", 32'(r0_err), 32'd0);
    chk("rd0_rdata", 32'(r0_rdata), 32'h0018);

    // r1 reads 0xFFC back-to-back
    r1_req = 1; r1_we = 0; r1_addr = 12'hFFC;
    step();
    chk("rd1_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd2);
    r1_req = 0;
    step();
    chk("rd1_done", {30'd0, r1_done, r0_done}, 32'd2);
    chk("rd1_rdata", 32'(r1_rdata), 32'hABCD);
    chk("rd1_r0_hold", 32'(r0_rdata), 32'h0018);

    // Odd address 0xFFF issues as 0xFFE
    r1_req = 1; r1_addr = 12'hFFF;
    step();
    chk("wrap_addr", 32'(mem_addr), 32'hFFE);
    r1_req = 0;
    step();
    chk("wrap_rdata", 32'(r1_rdata), 32'h1357);

    // r1 writes 0x5A5A to 0x802
    r1_req = 1; r1_we = 1; r1_addr = 12'h802; r1_wdata = 16'h5A5A;
    step();
    chk("wr1_we_access", 32'(mem_we), 32'd1);
    chk("wr1_gnt", 32'(r1_gnt), 32'd1);
    chk("wr1_wdata", 32'(mem_wdata), 32'h5A5A);
    r1_req = 0; r1_we = 0;
    step();
    chk("wr1_we_resp", 32'(mem_we), 32'd0);
    chk("wr1_done_err", {30'd0, r1_done, r1_err}, 32'd2);
    chk("wr1_rdata_kept", 32'(r1_rdata), 32'h1357);

    // r0 reads 0x803
    r0_req = 1; r0_addr = 12'h803;
    step();
    chk("rd803_addr", 32'(mem_addr), 32'h802);
    r0_req = 0;
    step();
    chk("rd803_rdata", 32'(r0_rdata), 32'h5A5A);

    // Write-protected write to 0x000
    r0_req = 1; r0_we = 1; r0_addr = 12'h000; r0_wdata = 16'h1234;
    step();
    chk("wp_gnt", 32'(r0_gnt), 32'd1);
    chk("wp_we", 32'(mem_we), 32'd0);
    r0_req = 0; r0_we = 0;
    step();
    chk("wp_done_err", {30'd0, r0_done, r0_err}, 32'd3);
    chk("wp_rdata_kept", 32'(r0_rdata), 32'h5A5A);
    r0_req = 1; r0_addr = 12'h000;
    step();
    r0_req = 0;
    step();
    chk("wp_readback", 32'(r0_rdata), 32'hF0C8);
    step();

    // Round-robin out of reset, lock=0
    rst = 1; step(); rst = 0;
    chk("rr_reset_ctrl", outs_vec(), 32'd0);
    r0_req = 1; r0_addr = 12'h412; r1_req = 1; r1_addr = 12'hFFC;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] pat;
      step();
      pat = ((k / 2) % 2 == 1) ? 2'b10 : 2'b01;
      if (k % 2 == 0) begin
        chk($sformatf("rr_gnt_%0d", k), {30'd0, r1_gnt, r0_gnt}, 32'(pat));
        chk($sformatf("rr_nodone_%0d", k), {30'd0, r1_done, r0_done}, 32'd0);
      end else begin
        chk($sformatf("rr_done_%0d", k), {30'd0, r1_done, r0_done}, 32'(pat));
        chk($sformatf("rr_nognt_%0d", k), {30'd0, r1_gnt, r0_gnt}, 32'd0);
      end
    end
    r0_req = 0; r1_req = 0;
    step();

    // Lock bound: r0 locked, r1 waiting
    rst = 1; step(); rst = 0;
    r0_req = 1; r0_lock = 1; r0_addr = 12'h412;
    r1_req = 1; r1_lock = 0; r1_addr = 12'hFFC;
    for (int s = 0; s < 10; s++) begin
      logic [1:0] pat;
      pat = (lock_exp[s] == 1) ? 2'b10 : 2'b01;
      step();
      chk($sformatf("lock_gnt_%0d", s), {30'd0, r1_gnt, r0_gnt}, 32'(pat));
      if (lock_exp[s] == 1) r1_req = 0;
      if (s == 9) r0_req = 0;
      step();
      chk($sformatf("lock_done_%0d", s), {30'd0, r1_done, r0_done}, 32'(pat));
    end
    r0_lock = 0;
    step();

    // Reset during the ACCESS of a write
    r0_req = 1; r0_we = 1; r0_addr = 12'h404; r0_wdata = 16'h1111;
    step();
    chk("rst_wr_we", 32'(mem_we), 32'd1);
    rst = 1; r0_req = 0; r0_we = 0;
    #1;
    chk("rst_async_ctrl", outs_vec(), 32'd0);
    chk("rst_async_addr", 32'(mem_addr), 32'h0);
    chk("rst_async_rdata", {r1_rdata, r0_rdata}, 32'h0);
    step();
    chk("rst_no_done", {30'd0, r1_done, r0_done}, 32'd0);
    rst = 0;
    chk("rst_mem_unchanged", 32'(mem[12'h404 >> 1]), 32'h7777);
    r0_req = 1; r0_addr = 12'h412; r1_req = 1; r1_addr = 12'hFFC;
    step();
    chk("rst_tie_r0", {30'd0, r1_gnt, r0_gnt}, 32'd1);
    r0_req = 0; r1_req = 0;
    step();
    chk("rst_tie_done", {30'd0, r1_done, r0_done}, 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
